// File: rtl/mem_slv_pkg.sv
// Shared definitions for the mem_slv host-bus memory responder: FSM states,
// error bit positions and the default out-of-range read pattern.
`timescale 1ns/1ps
package mem_slv_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_e;

  localparam int ERR_OOR   = 0;
  localparam int ERR_INIT  = 1;
  localparam int ERR_WPROT = 2;

  localparam logic [31:0] OOR_DATA_DEF = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_slv_ram.sv
// DEPTH x DW single-port synchronous array with registered read data.
// The write port is shared between the post-reset clearer and host writes.
`timescale 1ns/1ps
module mem_slv_ram #(
  parameter int DW    = 32,
  parameter int DEPTH = 256,
  parameter int AIW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_clr_en,
  input  logic [AIW-1:0] i_clr_addr,
  input  logic           i_host_we,
  input  logic           i_host_re,
  input  logic [AIW-1:0] i_addr,
  input  logic [DW-1:0]  i_wdata,
  output logic [DW-1:0]  o_rdata
);

  logic [DW-1:0]  r_mem [DEPTH];
  logic [DW-1:0]  r_rdata;
  logic           w_we;
  logic [AIW-1:0] w_waddr;
  logic [DW-1:0]  w_wdata;

  // The clearer owns the port during init; host writes are gated off then.
  assign w_we    = i_clr_en | i_host_we;
  assign w_waddr = i_clr_en ? i_clr_addr : i_addr;
  assign w_wdata = i_clr_en ? {DW{1'b0}} : i_wdata;

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= {DW{1'b0}};
    end else if (i_host_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_slv.sv
// Host memory-bus slave: init clearer FSM, range check, sticky errors, counters.
// Optional write protection (wprot port, err[2]) when MEM_SLV_WPROT_EN is defined.
`timescale 1ns/1ps
module mem_slv
  import mem_slv_pkg::*;
#(
  parameter int          DW       = 32,
  parameter int          AW       = 16,
  parameter int          DEPTH    = 256,
  parameter int          CW       = 16,
  parameter logic [31:0] OOR_DATA = OOR_DATA_DEF
) (
  input  logic          mclk,
  input  logic          mrstn,
`ifdef MEM_SLV_WPROT_EN
  input  logic          wprot,
`endif
  input  logic          mcsn_host,
  input  logic          mwr_host,
  input  logic [AW-1:0] maddr_host,
  input  logic [DW-1:0] mwdata_host,
  output logic [DW-1:0] mrdata_host,
  output logic          init_busy,
  output logic [2:0]    err,
  input  logic          err_clr,
  output logic [CW-1:0] wr_cnt,
  output logic [CW-1:0] rd_cnt
);

  localparam int             AIW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]    DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [AIW-1:0] LAST_PTR = AIW'(DEPTH - 1);
  localparam logic [DW-1:0]  OOR_W    = DW'(OOR_DATA);

  state_e         r_state;
  logic [AIW-1:0] r_ptr;
  logic           r_init_busy;
  logic [2:0]     r_err;
  logic [CW-1:0]  r_wr_cnt;
  logic [CW-1:0]  r_rd_cnt;
  logic           r_oor_rd;

  logic           w_wprot;
  logic           w_acc;
  logic           w_idle;
  logic           w_in_range;
  logic           w_wr_evt;
  logic           w_rd_evt;
  logic           w_host_we;
  logic           w_host_re;
  logic [2:0]     w_err_set;
  logic [DW-1:0]  w_ram_rdata;

`ifdef MEM_SLV_WPROT_EN
  assign w_wprot = wprot;
`else
  assign w_wprot = 1'b0;
`endif

  // Every use of address/data is qualified by chip select so X/Z cannot leak.
  assign w_acc      = ~mcsn_host;
  assign w_idle     = (r_state == ST_IDLE);
  assign w_in_range = ({1'b0, maddr_host} < DEPTH_W);
  assign w_wr_evt   = w_acc & w_idle & mwr_host & ~w_wprot;
  assign w_rd_evt   = w_acc & w_idle & ~mwr_host;
  assign w_host_we  = w_wr_evt & w_in_range;
  assign w_host_re  = w_rd_evt & w_in_range;

  assign w_err_set[ERR_OOR]   = (w_wr_evt | w_rd_evt) & ~w_in_range;
  assign w_err_set[ERR_INIT]  = w_acc & ~w_idle;
  assign w_err_set[ERR_WPROT] = w_acc & w_idle & mwr_host & w_wprot;

  always_ff @(posedge mclk or negedge mrstn) begin
    if (!mrstn) begin
      r_state     <= ST_INIT;
      r_ptr       <= {AIW{1'b0}};
      r_init_busy <= 1'b1;
    end else begin
      case (r_state)
        ST_INIT: begin
          if (r_ptr == LAST_PTR) begin
            r_state     <= ST_IDLE;
            r_init_busy <= 1'b0;
          end else begin
            r_ptr <= r_ptr + AIW'(1);
          end
        end
        ST_IDLE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state     <= ST_INIT;
          r_ptr       <= {AIW{1'b0}};
          r_init_busy <= 1'b1;
        end
      endcase
    end
  end

  // A new error event on the same edge as err_clr keeps its bit set.
  always_ff @(posedge mclk or negedge mrstn) begin
    if (!mrstn) begin
      r_err    <= 3'b000;
      r_wr_cnt <= {CW{1'b0}};
      r_rd_cnt <= {CW{1'b0}};
    end else begin
      r_err <= (err_clr ? 3'b000 : r_err) | w_err_set;
      if (w_wr_evt && !(&r_wr_cnt)) begin
        r_wr_cnt <= r_wr_cnt + CW'(1);
      end
      if (w_rd_evt && !(&r_rd_cnt)) begin
        r_rd_cnt <= r_rd_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge mclk or negedge mrstn) begin
    if (!mrstn) begin
      r_oor_rd <= 1'b0;
    end else if (w_rd_evt) begin
      r_oor_rd <= ~w_in_range;
    end
  end

  mem_slv_ram #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AIW   (AIW)
  ) u_ram (
    .clk        (mclk),
    .rst_n      (mrstn),
    .i_clr_en   (~w_idle),
    .i_clr_addr (r_ptr),
    .i_host_we  (w_host_we),
    .i_host_re  (w_host_re),
    .i_addr     (maddr_host[AIW-1:0]),
    .i_wdata    (mwdata_host),
    .o_rdata    (w_ram_rdata)
  );

  // Both sources are registers updated only by reads, so the value holds between reads.
  assign mrdata_host = r_oor_rd ? OOR_W : w_ram_rdata;
  assign init_busy   = r_init_busy;
  assign err         = r_err;
  assign wr_cnt      = r_wr_cnt;
  assign rd_cnt      = r_rd_cnt;

endmodule

// File: tb/tb_mem_slv.sv
// Self-checking bench for mem_slv: a default instance and a CW=4 instance share
// stimulus; a behavioural memory model is compared on every falling edge.
`timescale 1ns/1ps
module tb_mem_slv;

  logic        mclk = 1'b0;
  logic        mrstn;
  logic        mcsn_host;
  logic        mwr_host;
  logic [15:0] maddr_host;
  logic [31:0] mwdata_host;
  logic        err_clr;
  logic        wp;
`ifdef MEM_SLV_WPROT_EN
  logic        wprot;
  assign wprot = wp;
`endif

  logic [31:0] rd_a, rd_b;
  logic        busy_a, busy_b;
  logic [2:0]  err_a, err_b;
  logic [15:0] wc_a, rc_a;
  logic [3:0]  wc_b, rc_b;

  always #5 mclk = ~mclk;

  mem_slv u_dut (
    .mclk(mclk), .mrstn(mrstn),
`ifdef MEM_SLV_WPROT_EN
    .wprot(wprot),
`endif
    .mcsn_host(mcsn_host), .mwr_host(mwr_host), .maddr_host(maddr_host),
    .mwdata_host(mwdata_host), .mrdata_host(rd_a), .init_busy(busy_a),
    .err(err_a), .err_clr(err_clr), .wr_cnt(wc_a), .rd_cnt(rc_a)
  );

  mem_slv #(.CW(4)) u_dut4 (
    .mclk(mclk), .mrstn(mrstn),
`ifdef MEM_SLV_WPROT_EN
    .wprot(wprot),
`endif
    .mcsn_host(mcsn_host), .mwr_host(mwr_host), .maddr_host(maddr_host),
    .mwdata_host(mwdata_host), .mrdata_host(rd_b), .init_busy(busy_b),
    .err(err_b), .err_clr(err_clr), .wr_cnt(wc_b), .rd_cnt(rc_b)
  );

  // Behavioural model state
  logic [31:0] m_mem [256];
  int          m_init_left;
  logic [31:0] m_rdata;
  logic [2:0]  m_err;
  int          m_wr, m_rd;
  bit          chk_en = 1'b0;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 256; i++) m_mem[i] = 32'h0;
    m_init_left = 256;
    m_rdata     = 32'h0;
    m_err       = 3'b000;
    m_wr        = 0;
    m_rd        = 0;
  endtask

  task automatic model_step();
    logic [2:0] s;
    s = 3'b000;
    if (!mrstn) begin
      model_reset();
    end else begin
      if (!mcsn_host) begin
        if (m_init_left > 0) begin
          s[1] = 1'b1;
        end else if (mwr_host) begin
          if (wp) begin
            s[2] = 1'b1;
          end else begin
            m_wr++;
            if (maddr_host < 16'd256) m_mem[maddr_host[7:0]] = mwdata_host;
            else s[0] = 1'b1;
          end
        end else begin
          m_rd++;
          if (maddr_host < 16'd256) begin
            m_rdata = m_mem[maddr_host[7:0]];
          end else begin
            m_rdata = 32'hDEAD_BEEF;
            s[0] = 1'b1;
          end
        end
      end
      if (m_init_left > 0) m_init_left--;
      m_err = (err_clr ? 3'b000 : m_err) | s;
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge mclk);
      model_step();
      #1;
    end
  endtask

  task automatic idle();
    mcsn_host   = 1'b1;
    mwr_host    = 1'bx;
    maddr_host  = 16'hxxxx;
    mwdata_host = 32'hxxxx_xxxx;
  endtask

  task automatic acc(input bit wr, input logic [15:0] a, input logic [31:0] d);
    mcsn_host   = 1'b0;
    mwr_host    = wr;
    maddr_host  = a;
    mwdata_host = d;
    cyc(1);
    idle();
  endtask

  task automatic wait_init(input string name);
    int n;
    n = 0;
    while (busy_a === 1'b1 && n < 1000) begin
      cyc(1);
      n++;
    end
    check(name, n, 256);
  endtask

  always @(negedge mclk) begin
    if (chk_en) begin
      check("mrdata", rd_a, m_rdata);
      check("init_busy", busy_a, (m_init_left > 0));
      check("err", err_a, m_err);
      check("wr_cnt", wc_a, sat(m_wr, 65535));
      check("rd_cnt", rc_a, sat(m_rd, 65535));
      check("mrdata4", rd_b, m_rdata);
      check("err4", err_b, m_err);
      check("wr_cnt4", wc_b, sat(m_wr, 15));
      check("rd_cnt4", rc_b, sat(m_rd, 15));
    end
  end

  initial begin
    int n;
    mrstn   = 1'b0;
    err_clr = 1'b0;
    wp      = 1'b0;
    idle();
    model_reset();
    cyc(3);
    chk_en = 1'b1;
    check("rst_busy", busy_a, 1'b1);
    check("rst_rdata", rd_a, 32'h0);
    mrstn = 1'b1;

    // Init window with an ignored write on the tenth edge
    n = 0;
    while (busy_a === 1'b1 && n < 1000) begin
      if (n == 9) acc(1'b1, 16'h0005, 32'hFFFF_FFFF);
      else cyc(1);
      n++;
    end
    check("init_len", n, 256);
    check("lit_err_init", err_a, 3'b010);
    check("lit_wc_init", wc_a, 16'd0);

    acc(1'b0, 16'h0000, 32'h0);
    check("lit_rd0", rd_a, 32'h0);
    acc(1'b0, 16'h00FF, 32'h0);
    check("lit_rdff", rd_a, 32'h0);
    acc(1'b0, 16'h0005, 32'h0);
    check("lit_rd5", rd_a, 32'h0);
    err_clr = 1'b1; cyc(1); err_clr = 1'b0;
    check("lit_clr1", err_a, 3'b000);

    acc(1'b1, 16'h0010, 32'hA5A5_1234);
    acc(1'b0, 16'h0010, 32'h0);
    check("lit_rd10", rd_a, 32'hA5A5_1234);
    check("lit_wc1", wc_a, 16'd1);
    check("lit_rc4", rc_a, 16'd4);
    check("lit_err0", err_a, 3'b000);

    acc(1'b0, 16'h0100, 32'h0);
    check("lit_oor_rd", rd_a, 32'hDEAD_BEEF);
    check("lit_oor_err", err_a, 3'b001);
    acc(1'b1, 16'h0100, 32'h0000_0001);
    acc(1'b0, 16'h00FF, 32'h0);
    check("lit_noalias", rd_a, 32'h0);
    err_clr = 1'b1;
    acc(1'b0, 16'h0200, 32'h0);
    err_clr = 1'b0;
    check("lit_clr_vs_set", err_a, 3'b001);
    err_clr = 1'b1; cyc(1); err_clr = 1'b0;
    check("lit_clr2", err_a, 3'b000);

    acc(1'b1, 16'h0030, 32'hCAFE_F00D);
    acc(1'b0, 16'h0030, 32'h0);
    check("lit_raw", rd_a, 32'hCAFE_F00D);
    acc(1'b1, 16'h0031, 32'h1111_2222);
    check("lit_wr_keeps_rd", rd_a, 32'hCAFE_F00D);

    // Back-to-back writes with chip select held low
    for (int i = 0; i < 20; i++) begin
      mcsn_host = 1'b0; mwr_host = 1'b1;
      maddr_host = 16'h0040 + 16'(i);
      mwdata_host = 32'(i) * 32'd3 + 32'd7;
      cyc(1);
    end
    idle();
    check("lit_sat4", wc_b, 4'hF);
    check("lit_wc24", wc_a, 16'd24);
    for (int i = 0; i < 4; i++) begin
      mcsn_host = 1'b0; mwr_host = 1'b0;
      maddr_host = 16'h0040 + 16'(i);
      cyc(1);
    end
    idle();
    check("lit_rd43", rd_a, 32'd16);

    // Reset in the middle of a read
    acc(1'b1, 16'h0020, 32'h1234_5678);
    mcsn_host = 1'b0; mwr_host = 1'b0; maddr_host = 16'h0020;
    #2;
    mrstn = 1'b0;
    model_reset();
    idle();
    cyc(2);
    check("lit_rst_rd", rd_a, 32'h0);
    check("lit_rst_wc", wc_a, 16'd0);
    check("lit_rst_rc", rc_a, 16'd0);
    check("lit_rst_busy", busy_a, 1'b1);
    mrstn = 1'b1;
    wait_init("init_len2");
    acc(1'b0, 16'h0020, 32'h0);
    check("lit_rd20", rd_a, 32'h0);

`ifdef MEM_SLV_WPROT_EN
    wp = 1'b1;
    acc(1'b1, 16'h0001, 32'h0000_0055);
    wp = 1'b0;
    check("lit_wprot_err", err_a[2], 1'b1);
    acc(1'b0, 16'h0001, 32'h0);
    check("lit_wprot_rd", rd_a, 32'h0);
`endif

    cyc(2);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
